cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Sequencing controller for the 2-way set-associative, write-back cache array. It accepts one CPU request at a time and drives the cache array's lookup, write and fill ports. On a miss it runs the memory transactions: writeback of a dirty victim, then refill. It sits between the CPU load/store port and the main-memory request/acknowledge port, and keeps saturating hit, miss and writeback statistics.

## Interface
- ADDR_W, 8, byte-less word address width
- DATA_W, 16, word (= line) width
- TAG_W, 5, tag bits; index = addr[ADDR_W-TAG_W-1:0]
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  CPU request present
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  store data
- req_ready  out  1  controller idle, request accepted when valid&ready
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  load data (0 for stores)
- c_en  out  1  cache lookup strobe
- c_we  out  1  store into cache (on lookup: hit only; on fill: marks line dirty)
- c_fill  out  1  install line at c_addr: valid, MRU, dirty = c_we
- c_addr  out  ADDR_W  cache address
- c_wdata  out  DATA_W  cache write/fill data
- c_rdata  in  DATA_W  lookup data, valid cycle after c_en
- c_hit  in  1  lookup hit, valid cycle after c_en
- c_victim_dirty  in  1  LRU way of indexed set valid and dirty, valid cycle after c_en
- c_victim_addr  in  ADDR_W  victim {tag,index}
- c_victim_data  in  DATA_W  victim data
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion, sampled only while mem_req=1
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- hit_cnt, miss_cnt, wb_cnt  out  16 each  saturating statistics

## Operation
- Request fields latched on accept; outputs are Moore-decoded from registered state and registers only (no input→output combinational path).
- States: IDLE → LOOKUP → CHECK → {DONE | WB | REFILL | FILL}; WB → REFILL (load) or FILL (store); REFILL → FILL → DONE → IDLE.
- IDLE: req_ready=1; on valid&ready go LOOKUP.
- LOOKUP: c_en=1, c_we=req_write, c_addr/c_wdata = latched request.
- CHECK: evaluate c_hit/c_victim_*. Hit: hit_cnt++, capture c_rdata, go DONE. Miss: miss_cnt++, capture victim addr/data; dirty → WB; clean and load → REFILL; clean and store → FILL. Store misses are write-allocate without fetch (line = one word).
- WB: mem_req=1, mem_we=1, mem_addr/mem_wdata = captured victim; on mem_ack: wb_cnt++, then REFILL for a load or FILL for a store.
- REFILL: mem_req=1, mem_we=0, mem_addr = req_addr; on mem_ack capture mem_rdata, go FILL.
- FILL: c_fill=1, c_addr = req_addr, c_we = req_write, c_wdata = store ? req_wdata : captured mem_rdata.
- DONE: resp_valid=1, resp_rdata = load data or 0.
- Counters saturate at 0xFFFF.

## Timing
- Reset values: state IDLE, req_ready=1, every other output 0, counters 0.
- Load/store hit: accept edge N; LOOKUP in cycle N+1; CHECK in cycle N+2; resp_valid in cycle N+3.
- Miss: add (cycles until mem_ack) per memory phase, plus 1 FILL cycle. mem_ack may arrive in the first mem_req cycle.
- mem_req, mem_we, mem_addr and mem_wdata are stable from assertion until the ack edge. mem_req drops the cycle after ack.
- WB→REFILL has at least one cycle with mem_req=0 between phases.
- mem_ack while mem_req=0 is ignored. req_valid outside IDLE is ignored (req_ready=0).
- rst_n low mid-transaction: immediate return to IDLE and mem_req drops asynchronously. The abandoned memory transaction is not completed and no resp_valid is produced.

## Structure
- Package cache_ctrl_pkg holds the state enum and the default ADDR_W, DATA_W and TAG_W constants.
- Sub-module sat_counter (16-bit, increment enable, saturating, async active-low clear) is instantiated three times.

## Test plan
- Load hit at 0x2A, c_hit=1, c_rdata=0x5A5A → resp_valid 3 cycles after accept with 0x5A5A; no mem_req; hit_cnt=1.
- Load miss at 0x2A, clean victim, mem_ack 3 cycles later with 0xBEEF → single read of 0x2A; c_fill with 0xBEEF, c_we=0; resp_rdata=0xBEEF; miss_cnt=1.
- Load miss at 0x2A, dirty victim 0x12/0x1234 → memory write 0x12←0x1234, idle gap, read 0x2A, fill; wb_cnt=1.
- Store miss at 0x07, data 0xCAFE, clean victim → no memory read; c_fill=1, c_we=1, c_wdata=0xCAFE; resp_rdata=0.
- rst_n pulsed low during REFILL → mem_req=0 in the same cycle, all outputs at reset values, next request accepted normally.
- 65537 forced hits → hit_cnt holds 0xFFFF.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types and default geometry for the cache sequencing controller.
package cache_ctrl_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_TAG_W  = 5;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_CHECK, S_DONE, S_WB, S_REFILL, S_FILL
  } state_t;
endpackage

// File: rtl/cache_ctrl_sat_counter.sv
// Saturating up-counter with async active-low clear; used for cache statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)               q <= '0;
    else if (inc && q != '1)  q <= q + W'(1);
endmodule

// File: rtl/cache_ctrl.sv
// Miss-handling sequencer for a 2-way write-back cache: lookup, victim
// writeback, refill and fill, with Moore-decoded outputs.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              c_en,
  output logic              c_we,
  output logic              c_fill,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_wdata,
  input  logic [DATA_W-1:0] c_rdata,
  input  logic              c_hit,
  input  logic              c_victim_dirty,
  input  logic [ADDR_W-1:0] c_victim_addr,
  input  logic [DATA_W-1:0] c_victim_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt
);
  localparam int IDX_W = ADDR_W - TAG_W;

  state_t              state, state_nx;
  logic                wr_q, gap_q;
  logic [TAG_W-1:0]    tag_q;
  logic [IDX_W-1:0]    idx_q;
  logic [ADDR_W-1:0]   addr_q, vic_addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q, vic_data_q;
  logic                acked;

  assign addr_q = {tag_q, idx_q};
  assign acked  = mem_req & mem_ack;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_q       <= 1'b0;
      gap_q      <= 1'b0;
      tag_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      vic_addr_q <= '0;
      vic_data_q <= '0;
    end else begin
      state <= state_nx;
      // one idle mem_req cycle between writeback and refill
      gap_q <= (state == S_WB) && acked && !wr_q;
      if (state == S_IDLE && req_valid) begin
        wr_q    <= req_write;
        tag_q   <= req_addr[ADDR_W-1 -: TAG_W];
        idx_q   <= req_addr[IDX_W-1:0];
        wdata_q <= req_wdata;
      end
      if (state == S_CHECK) begin
        if (c_hit) rdata_q <= c_rdata;
        else begin
          vic_addr_q <= c_victim_addr;
          vic_data_q <= c_victim_data;
        end
      end
      if (state == S_REFILL && acked) rdata_q <= mem_rdata;
    end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (req_valid) state_nx = S_LOOKUP;
      S_LOOKUP: state_nx = S_CHECK;
      S_CHECK:
        if (c_hit)               state_nx = S_DONE;
        else if (c_victim_dirty) state_nx = S_WB;
        else if (wr_q)           state_nx = S_FILL;
        else                     state_nx = S_REFILL;
      S_WB:     if (acked) state_nx = wr_q ? S_FILL : S_REFILL;
      S_REFILL: if (acked) state_nx = S_FILL;
      S_FILL:   state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_DONE);
    resp_rdata = (state == S_DONE && !wr_q) ? rdata_q : '0;
    c_en       = (state == S_LOOKUP);
    c_fill     = (state == S_FILL);
    c_we       = (state == S_LOOKUP || state == S_FILL) && wr_q;
    c_addr     = '0;
    c_wdata    = '0;
    if (state == S_LOOKUP || state == S_FILL) c_addr = addr_q;
    if (state == S_LOOKUP) c_wdata = wdata_q;
    if (state == S_FILL)   c_wdata = wr_q ? wdata_q : rdata_q;
    mem_req    = (state == S_WB) || (state == S_REFILL && !gap_q);
    mem_we     = (state == S_WB);
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state == S_WB) begin
      mem_addr  = vic_addr_q;
      mem_wdata = vic_data_q;
    end else if (state == S_REFILL) begin
      mem_addr  = addr_q;
    end
  end

  sat_counter #(.W(CNT_W)) u_hit  (.clk(clk), .rst_n(rst_n), .inc(state == S_CHECK &&  c_hit), .q(hit_cnt));
  sat_counter #(.W(CNT_W)) u_miss (.clk(clk), .rst_n(rst_n), .inc(state == S_CHECK && !c_hit), .q(miss_cnt));
  sat_counter #(.W(CNT_W)) u_wb   (.clk(clk), .rst_n(rst_n), .inc(state == S_WB && acked),       .q(wb_cnt));
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: hit/miss/writeback sequences, reset abort,
// stray acks and counter saturation.
module tb_cache_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid, req_write, req_ready, resp_valid;
  logic [7:0]  req_addr, c_addr, c_victim_addr, mem_addr;
  logic [15:0] req_wdata, resp_rdata, c_wdata, c_rdata, c_victim_data, mem_wdata, mem_rdata;
  logic        c_en, c_we, c_fill, c_hit, c_victim_dirty, mem_req, mem_we, mem_ack;
  logic [15:0] hit_cnt, miss_cnt, wb_cnt;
  logic        sat_inc;
  logic [15:0] sat_q;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .c_en(c_en), .c_we(c_we),
    .c_fill(c_fill), .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata),
    .c_hit(c_hit), .c_victim_dirty(c_victim_dirty), .c_victim_addr(c_victim_addr),
    .c_victim_data(c_victim_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  sat_counter #(.W(16)) u_sat (.clk(clk), .rst_n(rst_n), .inc(sat_inc), .q(sat_q));

  int n_chk = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // transaction record filled by run_req
  int          lat, n_rd, n_wr, n_phase, unstable, en_seen;
  logic [7:0]  rd_addr, wr_addr, fill_addr;
  logic [15:0] wr_data, fill_data, resp_data, en_wd;
  logic        fill_seen, fill_we, en_we;

  task automatic run_req(input logic wr, input logic [7:0] addr, input logic [15:0] wd,
                         input int dly, input logic [15:0] mdata);
    int k;
    logic ph_we; logic [7:0] ph_addr; logic [15:0] ph_wd;
    lat = -1; n_rd = 0; n_wr = 0; n_phase = 0; unstable = 0; en_seen = 0;
    fill_seen = 0; fill_we = 0; fill_data = 0; fill_addr = 0; resp_data = 16'hdead;
    en_we = 0; en_wd = 0; k = 0; ph_we = 0; ph_addr = 0; ph_wd = 0;
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      tick;
      req_valid = 0;
      if (c_en) begin en_seen++; en_we = c_we; en_wd = c_wdata; end
      if (c_fill) begin fill_seen = 1; fill_we = c_we; fill_data = c_wdata; fill_addr = c_addr; end
      if (mem_req) begin
        if (k == 0) begin
          n_phase++; ph_we = mem_we; ph_addr = mem_addr; ph_wd = mem_wdata;
          if (mem_we) begin n_wr++; wr_addr = mem_addr; wr_data = mem_wdata; end
          else begin n_rd++; rd_addr = mem_addr; end
        end else if (mem_we !== ph_we || mem_addr !== ph_addr || mem_wdata !== ph_wd)
          unstable++;
        mem_ack   = (k == dly);
        mem_rdata = (k == dly) ? mdata : 16'h0;
        k++;
      end else begin
        k = 0; mem_ack = 0;
      end
      if (resp_valid) begin lat = cyc; resp_data = resp_rdata; break; end
    end
    mem_ack = 0;
    tick;
  endtask

  initial begin
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    c_rdata = 0; c_hit = 0; c_victim_dirty = 0; c_victim_addr = 0; c_victim_data = 0;
    mem_ack = 0; mem_rdata = 0; sat_inc = 0;
    #3;
    chk("rst_ready", req_ready, 1);
    chk("rst_memreq", mem_req, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_cen", c_en, 0);
    chk("rst_hitcnt", hit_cnt, 0);
    tick; rst_n = 1; tick;

    // stray ack while idle must be ignored
    mem_ack = 1; tick; tick;
    chk("stray_ready", req_ready, 1);
    chk("stray_memreq", mem_req, 0);
    mem_ack = 0;

    // load hit
    c_hit = 1; c_rdata = 16'h5A5A;
    run_req(0, 8'h2A, 16'h0, 0, 16'h0);
    chk("lh_lat", lat, 3);
    chk("lh_data", resp_data, 16'h5A5A);
    chk("lh_nomem", n_phase, 0);
    chk("lh_hitcnt", hit_cnt, 1);
    chk("lh_ready", req_ready, 1);

    // store hit writes through lookup port
    run_req(1, 8'h15, 16'h1111, 0, 16'h0);
    chk("sh_lat", lat, 3);
    chk("sh_resp0", resp_data, 0);
    chk("sh_en", en_seen, 1);
    chk("sh_we", en_we, 1);
    chk("sh_wd", en_wd, 16'h1111);
    chk("sh_hitcnt", hit_cnt, 2);

    // clean load miss, ack on 3rd mem_req cycle
    c_hit = 0; c_victim_dirty = 0; c_victim_addr = 8'h33; c_victim_data = 16'h9999;
    run_req(0, 8'h2A, 16'h0, 2, 16'hBEEF);
    chk("lm_lat", lat, 7);
    chk("lm_nrd", n_rd, 1);
    chk("lm_nwr", n_wr, 0);
    chk("lm_rdaddr", rd_addr, 8'h2A);
    chk("lm_fill", fill_seen, 1);
    chk("lm_fillwe", fill_we, 0);
    chk("lm_filldata", fill_data, 16'hBEEF);
    chk("lm_filladdr", fill_addr, 8'h2A);
    chk("lm_resp", resp_data, 16'hBEEF);
    chk("lm_stable", unstable, 0);
    chk("lm_misscnt", miss_cnt, 1);

    // dirty load miss, immediate acks
    c_victim_dirty = 1; c_victim_addr = 8'h12; c_victim_data = 16'h1234;
    run_req(0, 8'h2A, 16'h0, 0, 16'h4321);
    chk("dm_lat", lat, 7);
    chk("dm_phases", n_phase, 2);
    chk("dm_nwr", n_wr, 1);
    chk("dm_wraddr", wr_addr, 8'h12);
    chk("dm_wrdata", wr_data, 16'h1234);
    chk("dm_nrd", n_rd, 1);
    chk("dm_rdaddr", rd_addr, 8'h2A);
    chk("dm_resp", resp_data, 16'h4321);
    chk("dm_wbcnt", wb_cnt, 1);
    chk("dm_misscnt", miss_cnt, 2);

    // clean store miss: allocate without fetch
    c_victim_dirty = 0;
    run_req(1, 8'h07, 16'hCAFE, 0, 16'h0);
    chk("sm_lat", lat, 4);
    chk("sm_nomem", n_phase, 0);
    chk("sm_fillwe", fill_we, 1);
    chk("sm_filldata", fill_data, 16'hCAFE);
    chk("sm_filladdr", fill_addr, 8'h07);
    chk("sm_resp0", resp_data, 0);
    chk("sm_misscnt", miss_cnt, 3);

    // dirty store miss: writeback then fill, no read
    c_victim_dirty = 1; c_victim_addr = 8'h55; c_victim_data = 16'hAAAA;
    run_req(1, 8'h3C, 16'h7777, 1, 16'h0);
    chk("ds_lat", lat, 6);
    chk("ds_nwr", n_wr, 1);
    chk("ds_nrd", n_rd, 0);
    chk("ds_wraddr", wr_addr, 8'h55);
    chk("ds_filldata", fill_data, 16'h7777);
    chk("ds_stable", unstable, 0);
    chk("ds_wbcnt", wb_cnt, 2);

    // reset during REFILL
    c_victim_dirty = 0;
    req_valid = 1; req_write = 0; req_addr = 8'h2A;
    tick; req_valid = 0;
    chk("ra_busy", req_ready, 0);
    tick; tick;
    chk("ra_memreq", mem_req, 1);
    #2 rst_n = 0;
    #1;
    chk("ra_memdrop", mem_req, 0);
    chk("ra_ready", req_ready, 1);
    chk("ra_resp", resp_valid, 0);
    chk("ra_cfill", c_fill, 0);
    chk("ra_misscnt", miss_cnt, 0);
    tick; rst_n = 1; tick;
    c_hit = 1; c_rdata = 16'h0F0F;
    run_req(0, 8'h01, 16'h0, 0, 16'h0);
    chk("ra_next_lat", lat, 3);
    chk("ra_next_data", resp_data, 16'h0F0F);
    chk("ra_hitcnt", hit_cnt, 1);

    // counter saturation
    sat_inc = 1;
    for (int i = 0; i < 65534; i++) tick;
    chk("sat_fffe", sat_q, 16'hFFFE);
    tick; tick; tick;
    chk("sat_ffff", sat_q, 16'hFFFF);
    sat_inc = 0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
